// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared state encoding and latency counter width for the SAR search
package sar_pkg;

  // Width of the comparator-latency counter; CMP_LAT never exceeds 3.
  localparam int LAT_CNT_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_TRIAL = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sar_lat_counter.sv
// rtl/sar_lat_counter.sv - loadable down-counter that times the comparator settle window
module sar_lat_counter
  import sar_pkg::*;
(
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iLoad,
  input  logic [LAT_CNT_W-1:0] iLoadVal,
  output logic                 oZero
);

  logic [LAT_CNT_W-1:0] cnt_q;

  // Load on entry to WAIT, then count down and rest at zero.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt_q <= '0;
    end else if (iLoad) begin
      cnt_q <= iLoadVal;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign oZero = (cnt_q == '0);

endmodule

// File: rtl/sar_search.sv
// rtl/sar_search.sv - successive-approximation search against an external comparator
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int CMP_LAT = 0
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic             iGE,
  output logic [WIDTH-1:0] oCand,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResult
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // WAIT spans CMP_LAT cycles: the counter is loaded with CMP_LAT-1 and WAIT
  // exits on the cycle it reads zero.
  localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
    (CMP_LAT > 0) ? LAT_CNT_W'(CMP_LAT - 1) : '0;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] cand_trial;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q;
  logic             cnt_load;
  logic             cnt_zero;

  // With CMP_LAT=0 WAIT is never entered and the counter is never loaded.
  sar_lat_counter u_lat_counter (
    .iClk     (iClk),
    .iRst_n   (iRst_n),
    .iLoad    (cnt_load),
    .iLoadVal (LAT_LOAD),
    .oZero    (cnt_zero)
  );

  // Next-state logic: one candidate bit is resolved per TRIAL cycle, MSB first.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    idx_d      = idx_q;
    result_d   = result_q;
    cnt_load   = 1'b0;
    cand_trial = cand_q;
    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          cand_d = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d  = IDX_W'(WIDTH - 1);
          if (CMP_LAT > 0) begin
            state_d  = S_WAIT;
            cnt_load = 1'b1;
          end else begin
            state_d = S_TRIAL;
          end
        end
      end
      S_WAIT: begin
        if (cnt_zero) state_d = S_TRIAL;
      end
      S_TRIAL: begin
        // The trial bit is already 1, so it simply takes the comparator answer.
        cand_trial[idx_q] = iGE;
        if (idx_q != '0) begin
          cand_trial[idx_q - 1'b1] = 1'b1;
          idx_d = idx_q - 1'b1;
          if (CMP_LAT > 0) begin
            state_d  = S_WAIT;
            cnt_load = 1'b1;
          end
        end else begin
          result_d = cand_trial;
          state_d  = S_DONE;
        end
        cand_d = cand_trial;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; oDone is the registered echo of the DONE state.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q  <= S_IDLE;
      cand_q   <= '0;
      idx_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      done_q   <= (state_q == S_DONE);
    end
  end

  assign oCand   = cand_q;
  assign oResult = result_q;
  assign oDone   = done_q;
  assign oBusy   = (state_q == S_TRIAL) || (state_q == S_WAIT);

endmodule

// File: tb/tb_sar_search.sv
// tb/tb_sar_search.sv - directed self-checking bench for sar_search
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start0, start2;
  logic [3:0] t0, t2;
  logic [3:0] cand0, res0, cand2, res2;
  logic       busy0, done0, busy2, done2;
  logic       ge0, ge2;
  logic [3:0] c2_d1, c2_d2;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Comparator models: immediate for dut0, two-cycle delayed candidate for dut2.
  assign ge0 = (t0 >= cand0);
  always @(posedge clk) begin
    c2_d1 <= cand2;
    c2_d2 <= c2_d1;
  end
  assign ge2 = (t2 >= c2_d2);

  sar_search #(.WIDTH(4), .CMP_LAT(0)) dut0 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start0), .iGE(ge0),
    .oCand(cand0), .oBusy(busy0), .oDone(done0), .oResult(res0)
  );

  sar_search #(.WIDTH(4), .CMP_LAT(2)) dut2 (
    .iClk(clk), .iRst_n(rst_n), .iStart(start2), .iGE(ge2),
    .oCand(cand2), .oBusy(busy2), .oDone(done2), .oResult(res2)
  );

  // Leaves the bench at the negedge just after the edge that sampled iStart (k=0).
  task automatic start_dut0();
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic start_dut2();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0; t0 = 4'd0; t2 = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cand0, res0, busy0, done0} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut0 got cand=%0d res=%0d busy=%b done=%b want all 0", cand0, res0, busy0, done0);
    end
    checks++;
    if ({cand2, res2, busy2, done2} !== 10'd0) begin
      errors++;
      $display("FAIL reset_dut2 got cand=%0d res=%0d busy=%b done=%b want all 0", cand2, res2, busy2, done2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start got busy=%b want 0", busy0);
    end
  endtask

  task automatic test_t9();
    logic [3:0] ec[4] = '{4'd8, 4'd12, 4'd10, 4'd9};
    logic       eg[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    t0 = 4'd9;
    start_dut0();
    for (int k = 0; k < 7; k++) begin
      if (k < 4) begin
        checks++;
        if (cand0 !== ec[k] || ge0 !== eg[k] || busy0 !== 1'b1) begin
          errors++;
          $display("FAIL t9_step%0d got cand=%0d ge=%b busy=%b want cand=%0d ge=%b busy=1", k, cand0, ge0, busy0, ec[k], eg[k]);
        end
      end else begin
        checks++;
        if (done0 !== (k == 5) || busy0 !== 1'b0 || cand0 !== 4'd9) begin
          errors++;
          $display("FAIL t9_tail%0d got done=%b busy=%b cand=%0d want done=%b busy=0 cand=9", k, done0, busy0, cand0, (k == 5));
        end
      end
      if (k == 5) begin
        checks++;
        if (res0 !== 4'd9) begin
          errors++;
          $display("FAIL t9_result got %0d want 9", res0);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_edges();
    logic [3:0] tv[2] = '{4'd0, 4'd15};
    for (int r = 0; r < 2; r++) begin
      int dcnt;
      dcnt = 0;
      t0 = tv[r];
      start_dut0();
      for (int k = 0; k < 8; k++) begin
        if (done0 === 1'b1) dcnt++;
        if (k == 5) begin
          checks++;
          if (done0 !== 1'b1 || res0 !== tv[r]) begin
            errors++;
            $display("FAIL edge_t%0d got done=%b res=%0d want done=1 res=%0d", tv[r], done0, res0, tv[r]);
          end
        end
        @(negedge clk);
      end
      checks++;
      if (dcnt !== 1) begin
        errors++;
        $display("FAIL edge_t%0d_pulse got %0d done cycles want 1", tv[r], dcnt);
      end
    end
  endtask

  task automatic test_lat2();
    logic [3:0] ec[4] = '{4'd8, 4'd4, 4'd6, 4'd5};
    t2 = 4'd5;
    start_dut2();
    for (int k = 0; k < 15; k++) begin
      if (k < 12) begin
        checks++;
        if (cand2 !== ec[k/3] || busy2 !== 1'b1 || done2 !== 1'b0) begin
          errors++;
          $display("FAIL lat2_step%0d got cand=%0d busy=%b done=%b want cand=%0d busy=1 done=0", k, cand2, busy2, done2, ec[k/3]);
        end
      end else begin
        checks++;
        if (done2 !== (k == 13) || busy2 !== 1'b0 || res2 !== 4'd5) begin
          errors++;
          $display("FAIL lat2_tail%0d got done=%b busy=%b res=%0d want done=%b busy=0 res=5", k, done2, busy2, res2, (k == 13));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int dcnt;
    dcnt = 0;
    t0 = 4'd9;
    start_dut0();
    for (int k = 0; k < 11; k++) begin
      // High across edges e2 and e5: TRIAL and DONE respectively.
      start0 = (k == 1 || k == 4);
      if (done0 === 1'b1) dcnt++;
      if (k == 7) begin
        checks++;
        if (busy0 !== 1'b0 || res0 !== 4'd9) begin
          errors++;
          $display("FAIL ign_state got busy=%b res=%0d want busy=0 res=9", busy0, res0);
        end
      end
      @(negedge clk);
    end
    start0 = 1'b0;
    checks++;
    if (dcnt !== 1) begin
      errors++;
      $display("FAIL ign_pulses got %0d done cycles want 1", dcnt);
    end
    t0 = 4'd3;
    start_dut0();
    repeat (5) @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || res0 !== 4'd3) begin
      errors++;
      $display("FAIL ign_next got done=%b res=%0d want done=1 res=3", done0, res0);
    end
  endtask

  task automatic test_reset_abort();
    int dcnt;
    dcnt = 0;
    t0 = 4'd9;
    start_dut0();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cand0, res0, busy0, done0} !== 10'd0) begin
      errors++;
      $display("FAIL abort_async got cand=%0d res=%0d busy=%b done=%b want all 0", cand0, res0, busy0, done0);
    end
    checks++;
    if (res2 !== 4'd0) begin
      errors++;
      $display("FAIL abort_dut2 got res=%0d want 0", res2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (done0 === 1'b1) dcnt++;
      @(negedge clk);
    end
    checks++;
    if (dcnt !== 0 || res0 !== 4'd0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL abort_after got done_cycles=%0d res=%0d busy=%b want 0 0 0", dcnt, res0, busy0);
    end
    t0 = 4'd6;
    start_dut0();
    repeat (5) @(negedge clk);
    checks++;
    if (done0 !== 1'b1 || res0 !== 4'd6) begin
      errors++;
      $display("FAIL abort_restart got done=%b res=%0d want done=1 res=6", done0, res0);
    end
  endtask

  initial begin
    test_reset();
    test_t9();
    test_edges();
    test_lat2();
    test_start_ignored();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
REQ-001 Parameter WIDTH, default 4: bit width of the candidate and result (legal 2..16).
REQ-002 Parameter CMP_LAT, default 0: cycles between a candidate change and a valid iGE (legal 0..3).
REQ-003 iClk  input  1  single clock; all state updates on the rising edge.
REQ-004 iRst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 iStart  input  1  request a new search; sampled only in IDLE.
REQ-006 iGE  input  1  external comparator result: 1 = target >= oCand.
REQ-007 oCand  output  WIDTH  trial value driven to the external comparator.
REQ-008 oBusy  output  1  high while a search is in progress (TRIAL or WAIT).
REQ-009 oDone  output  1  one-cycle pulse when oResult is updated.
REQ-010 oResult  output  WIDTH  last completed search result; held until the next completion.

Function
REQ-011 Result definition: the largest c in 0..2^WIDTH-1 with target >= c; this equals the target when the target is in range.
REQ-012 FSM states: IDLE, TRIAL, WAIT, DONE.
REQ-013 IDLE with iStart=1 at an edge goes to TRIAL (CMP_LAT=0) or WAIT (CMP_LAT>0):
- oCand = MSB only;
- bit index = WIDTH-1;
- oBusy = 1.
REQ-014 WAIT counts CMP_LAT cycles, holds oCand constant, then goes to TRIAL.
REQ-015 At the TRIAL edge, iGE is sampled:
- iGE=0: clear the current bit of oCand;
- iGE=1: keep the current bit.
REQ-016 After the REQ-015 sample, if index > 0:
- set the next lower bit;
- decrement index;
- go to WAIT (CMP_LAT>0) or stay in TRIAL.
REQ-017 After the REQ-015 sample, if index = 0:
- load oResult with the final candidate;
- go to DONE.
REQ-018 DONE asserts oDone for exactly one cycle, then returns to IDLE.
REQ-019 oBusy is deasserted in DONE.
REQ-020 Latency: oDone is high in the cycle that begins WIDTH*(CMP_LAT+1)+1 edges after the edge that sampled iStart.
REQ-021 iStart is ignored in TRIAL, WAIT and DONE; it is neither queued nor able to restart a search.
REQ-022 After completion, oCand holds its final value until the next start.
REQ-023 iGE is ignored outside TRIAL.

Reset
REQ-024 iRst_n=0 immediately forces, independent of iClk:
- state = IDLE;
- oCand = 0, oResult = 0;
- oBusy = 0, oDone = 0;
- index and wait counter = 0.
REQ-025 A reset during a search aborts it; no oDone is produced and oResult stays 0.
REQ-026 The first search after reset release requires a fresh iStart in IDLE.

Structure
REQ-027 Package sar_pkg holds the state encoding constants and the CMP_LAT counter width constant.
REQ-028 One sub-module, sar_lat_counter: loadable down-counter for WAIT; it is bypassed when CMP_LAT=0.

Verification
REQ-029 The bench drives iGE from a combinational comparator model with target T and latency CMP_LAT.
REQ-030 WIDTH=4, CMP_LAT=0, T=9:
- oCand sequence 8,12,10,9;
- iGE sequence 1,0,0,1;
- oResult=9 and oDone pulse at cycle 5 after the start edge.
REQ-031 WIDTH=4, CMP_LAT=0, T=0 -> oResult=0, and the T=15 run -> oResult=15; oDone is a single-cycle pulse each time.
REQ-032 WIDTH=4, CMP_LAT=2, T=5:
- each oCand is held for 3 cycles;
- oResult=5 and oDone at cycle 13 after the start edge.
REQ-033 With T=9, iStart is pulsed at cycles 2 and 5 of the search; the pulses are ignored, exactly one oDone occurs, then the next start with T=3 gives 3.
REQ-034 With T=9, iRst_n is asserted low at cycle 2:
- all outputs go to 0 asynchronously;
- no oDone occurs;
- a new start after release with T=6 gives oResult=6.
